// File: rtl/router_idata_fifo.sv
// Router input-data FIFO: DEPTH x WIDTH register storage with first-word fall-through,
// synchronous flush, and a sticky overflow flag for pushes attempted while full.
module router_idata_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             ovf_err
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A full FIFO refuses the push even when a pop frees a slot on the same edge.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // NOTE: storage is reset so out_data is a defined 0 after reset rather than X;
  // flush deliberately leaves entries alone since only the pointers define validity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (in_valid && !in_ready && !flush) ovf_err <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_idata_fifo.sv
// Directed bench for router_idata_fifo (WIDTH=32, DEPTH=4): vector table plus
// hand-written sequences for streaming, flush and asynchronous reset.
module tb_router_idata_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             ovf_err;

  int errors = 0;
  int checks = 0;

  router_idata_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] din;
    logic             ordy;
    logic             fl;
    logic [CW-1:0]    cnt;
    logic             ov;
    logic             ir;
    logic [WIDTH-1:0] dout;
    logic             ovf;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [CW-1:0] cnt, input logic ov,
                             input logic ir, input logic [WIDTH-1:0] dout, input logic ovf,
                             input logic chk_data);
    check({tag, ".count"},     64'(count),     64'(cnt));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
    check({tag, ".ovf_err"},   64'(ovf_err),   64'(ovf));
    if (chk_data) check({tag, ".out_data"}, 64'(out_data), 64'(dout));
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] din, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic iv, input logic [WIDTH-1:0] din, input logic ordy, input logic fl);
    drive(iv, din, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            iv  din            ordy fl   cnt ov ir  dout           ovf
    vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0002, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0005, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0006, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 32'h0000_0003, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_0004, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0011, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_0011, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0012, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h0000_0011, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_0013, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h0000_0011, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_0014, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_0021, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_0021, 1'b1};

    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #12;
    check_state("reset", 3'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);

    @(negedge clk);
    reset = 1'b1;

    // Table: single push latency, fill to full, overflow, pop-while-full,
    // drain, pop on empty, flush with push+pop, and restart at pointer 0.
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir,
                  vecs[i].dout, vecs[i].ovf, vecs[i].ov);
    end

    // Streaming: bring occupancy to 2, then push and pop together for 16 cycles.
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain.count", 64'(count), 64'd0);
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h101, 1'b0, 1'b0);
    check("prime.count", 64'(count), 64'd2);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h102 + WIDTH'(i), 1'b1, 1'b0);
      check($sformatf("stream%0d.count", i), 64'(count), 64'd2);
      check($sformatf("stream%0d.data", i), 64'(out_data), 64'(32'h101 + i));
    end

    // Asynchronous reset between edges while count=2 and a transfer is presented.
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 3'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    check_state("post_rst", 3'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0055, 1'b0, 1'b0);
    check_state("first_push", 3'd1, 1'b1, 1'b1, 32'h55, 1'b0, 1'b1);

    // A refused push while full and flushing must not set the overflow flag.
    step(1'b1, 32'h56, 1'b0, 1'b0);
    step(1'b1, 32'h57, 1'b0, 1'b0);
    step(1'b1, 32'h58, 1'b0, 1'b0);
    check("refill.in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h59, 1'b0, 1'b1);
    check_state("flush_full", 3'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_idata_fifo.md
ROUTER_IDATA_FIFO -- requirements
Module: router_idata_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data bits per flit (legal range 1..256).
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of entries (power of two, 2..64).
REQ-003 The block SHALL have parameter CW, default $clog2(DEPTH+1), the width of the count output (derived, not overridden).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all stored entries.
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  block can accept a flit this cycle.
REQ-009 in_data  input  WIDTH  incoming flit.
REQ-010 out_valid  output  1  out_data holds the oldest stored flit.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  WIDTH  oldest stored flit.
REQ-013 count  output  CW  number of stored entries, 0..DEPTH.
REQ-014 ovf_err  output  1  sticky flag: in_valid was asserted while in_ready was low and flush was low.

Function
REQ-015 Push SHALL occur on a rising edge when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-016 in_ready SHALL equal (count != DEPTH); a full FIFO SHALL NOT accept a push, even if a pop occurs in the same cycle.
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer (first-word fall-through), with no combinational path from in_data.
REQ-018 Latency: a flit pushed into an empty FIFO at edge N SHALL appear with out_valid high in the cycle following edge N.
REQ-019 Storage SHALL be DEPTH x WIDTH registers, with wr_ptr and rd_ptr of $clog2(DEPTH) bits each; each pointer SHALL wrap from DEPTH-1 to 0.
REQ-020 count SHALL change by +1 on a push-only cycle, by -1 on a pop-only cycle, and by 0 on a simultaneous push and pop.
REQ-021 A simultaneous push and pop with 0 < count < DEPTH SHALL write the new flit and advance both pointers; the order of flits SHALL be preserved.
REQ-022 Pop with count==0 cannot occur, since out_valid is low; out_ready SHALL be ignored while empty.
REQ-023 flush SHALL have priority over push and pop: on that edge count, wr_ptr and rd_ptr SHALL go to 0, and in_data SHALL NOT be stored.
REQ-024 flush SHALL NOT clear ovf_err.
REQ-025 ovf_err SHALL set on the edge after any cycle where in_valid=1, in_ready=0 and flush=0; it SHALL clear only on reset.
REQ-026 Data stored in entries that are not valid SHALL have no observable effect; out_data while out_valid=0 is don't-care but SHALL be stable (no X propagation from uninitialised storage after reset).
REQ-027 Entry contents SHALL change only on a push to that entry.

Reset
REQ-028 While reset=0: count=0, wr_ptr=0, rd_ptr=0, out_valid=0, in_ready=1, ovf_err=0, and all storage entries = 0 (so out_data=0).
REQ-029 Assertion of reset SHALL take effect immediately, without a clock edge, including mid-transfer; flits in flight SHALL be discarded.
REQ-030 Deassertion of reset SHALL be synchronous to clk via an external synchroniser; the first push SHALL be accepted on the first rising edge after deassertion.

Verification
REQ-031 Reset, then push 0xA5A5_0001 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5_0001, count=1.
REQ-032 DEPTH=4, push 4 flits 1..4 with out_ready=0 -> count=4, in_ready=0; push 5 held valid -> ovf_err=1 next cycle, 5 not stored; then pop -> outputs 1,2,3,4 in order.
REQ-033 Continuous push and pop with count=2 for 16 cycles -> count stays 2, pointers wrap 4 times, output sequence equals input sequence delayed by 2 flits.
REQ-034 count=3, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; ovf_err unchanged.
REQ-035 reset driven low asynchronously between edges while count=2 -> outputs reach their reset values before the next edge; after release, count=0 and out_data=0.
REQ-036 Full FIFO (count=DEPTH), in_valid=1 and out_ready=1 in the same cycle -> pop only, count=DEPTH-1, incoming flit not stored, ovf_err=1.
